// File: rtl/qspi_target.sv
// rtl/qspi_target.sv - quad-SPI responder bridging an external master to a byte-wide local memory port
module qspi_target #(
    parameter int         ADDRESS_WIDTH = 16,
    parameter int         DUMMY_CYCLES  = 6,
    parameter logic [7:0] CMD_READ      = 8'h0B,
    parameter logic [7:0] CMD_WRITE     = 8'h02
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     spi_clk_in,
    input  logic                     spi_cs_n_in,
    input  logic [3:0]               spi_data_in,
    output logic [3:0]               spi_data_out,
    output logic [3:0]               spi_data_oe,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    output logic                     mem_we,
    output logic                     mem_rd_req,
    input  logic [7:0]               mem_rd_data,
    input  logic                     mem_rd_valid,
    output logic                     busy,
    output logic                     rd_underrun
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE} state_t;

    localparam logic [7:0] DUMMY_N = 8'(DUMMY_CYCLES);

    state_t                   state_q, state_d;
    logic [2:0]               sck_q, cs_q;
    logic [3:0]               din1_q, din_q;
    logic [7:0]               cnt_q, cnt_d;
    logic [19:0]              sr_q, sr_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               wdata_q, wdata_d, pf_q, pf_d, cur_q, cur_d;
    logic [3:0]               dout_q, dout_d, oe_q, oe_d;
    logic                     we_q, we_d, req_q, req_d, pf_valid_q, pf_valid_d;
    logic                     nib_q, nib_d, is_rd_q, is_rd_d, unr_q, unr_d;
    logic                     discard_q, discard_d, refetch_q, refetch_d;
    logic                     sck_rise, sck_fall, cs_rise, cs_fall, present_hi;

    // [0],[1] form the synchronizer; [2] is the previous synchronized sample for edge detection
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sck_q <= '0; cs_q <= '0; din1_q <= '0; din_q <= '0;
            state_q <= IDLE; cnt_q <= '0; sr_q <= '0; addr_q <= '0; wdata_q <= '0;
            pf_q <= '0; cur_q <= '0; dout_q <= '0; oe_q <= '0;
            we_q <= 1'b0; req_q <= 1'b0; pf_valid_q <= 1'b0; nib_q <= 1'b0;
            is_rd_q <= 1'b0; unr_q <= 1'b0; discard_q <= 1'b0; refetch_q <= 1'b0;
        end else begin
            sck_q <= {sck_q[1:0], spi_clk_in};
            cs_q  <= {cs_q[1:0], spi_cs_n_in};
            din1_q <= spi_data_in; din_q <= din1_q;
            state_q <= state_d; cnt_q <= cnt_d; sr_q <= sr_d; addr_q <= addr_d; wdata_q <= wdata_d;
            pf_q <= pf_d; cur_q <= cur_d; dout_q <= dout_d; oe_q <= oe_d;
            we_q <= we_d; req_q <= req_d; pf_valid_q <= pf_valid_d; nib_q <= nib_d;
            is_rd_q <= is_rd_d; unr_q <= unr_d; discard_q <= discard_d; refetch_q <= refetch_d;
        end
    end

    always_comb begin
        state_d = state_q; cnt_d = cnt_q; sr_d = sr_q; addr_d = addr_q; wdata_d = wdata_q;
        pf_d = pf_q; cur_d = cur_q; dout_d = dout_q; oe_d = oe_q;
        we_d = 1'b0; req_d = req_q; pf_valid_d = pf_valid_q; nib_d = nib_q;
        is_rd_d = is_rd_q; unr_d = unr_q; discard_d = discard_q; refetch_d = refetch_q;
        present_hi = 1'b0;

        if (we_q) addr_d = addr_q + ADDRESS_WIDTH'(1);

        // A discarded completion either retires the request or, if a newer fetch queued up, keeps it raised
        if (req_q && mem_rd_valid) begin
            if (discard_q) begin
                discard_d = 1'b0;
                if (refetch_q) refetch_d = 1'b0;
                else           req_d = 1'b0;
            end else begin
                pf_d = mem_rd_data; pf_valid_d = 1'b1; req_d = 1'b0;
            end
        end

        if (cs_rise) begin
            state_d = IDLE; oe_d = 4'h0; dout_d = 4'h0; req_d = 1'b0;
            discard_d = 1'b0; refetch_d = 1'b0; pf_valid_d = 1'b0; nib_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) begin
                    state_d = CMD; cnt_d = '0; nib_d = 1'b0; unr_d = 1'b0; pf_valid_d = 1'b0;
                end
                CMD: if (sck_rise) begin
                    sr_d = {sr_q[15:0], din_q};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        cnt_d = '0;
                        if ({sr_q[3:0], din_q} == CMD_READ) begin
                            state_d = ADDR; is_rd_d = 1'b1;
                        end else if ({sr_q[3:0], din_q} == CMD_WRITE) begin
                            state_d = ADDR; is_rd_d = 1'b0;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR: if (sck_rise) begin
                    sr_d = {sr_q[15:0], din_q};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd5) begin
                        cnt_d = '0; nib_d = 1'b0; pf_valid_d = 1'b0;
                        addr_d = ADDRESS_WIDTH'({sr_q[19:0], din_q});
                        if (is_rd_q) begin
                            state_d = DUMMY; req_d = 1'b1;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise && cnt_q != DUMMY_N) cnt_d = cnt_q + 8'd1;
                    if (sck_fall && cnt_q == DUMMY_N) present_hi = 1'b1;
                end
                RD_DATA: if (sck_fall) begin
                    if (nib_q) begin
                        dout_d = cur_q[3:0]; nib_d = 1'b0;
                        addr_d = addr_q + ADDRESS_WIDTH'(1);
                        if (req_d) begin
                            refetch_d = 1'b1; discard_d = 1'b1;
                        end else begin
                            req_d = 1'b1;
                        end
                    end else begin
                        present_hi = 1'b1;
                    end
                end
                WR_DATA: if (sck_rise) begin
                    sr_d = {sr_q[15:0], din_q};
                    nib_d = ~nib_q;
                    if (nib_q) begin
                        wdata_d = {sr_q[3:0], din_q}; we_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // A byte that missed its deadline is sent as zero and its late data is thrown away
        if (present_hi) begin
            cur_d  = pf_valid_q ? pf_q : 8'h00;
            dout_d = pf_valid_q ? pf_q[7:4] : 4'h0;
            if (!pf_valid_q) begin
                unr_d = 1'b1; discard_d = req_d;
            end
            pf_valid_d = 1'b0; nib_d = 1'b1; oe_d = 4'hF; state_d = RD_DATA;
        end
    end

    assign spi_data_out = dout_q;
    assign spi_data_oe  = oe_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_we       = we_q;
    assign mem_rd_req   = req_q;
    assign busy         = (state_q != IDLE);
    assign rd_underrun  = unr_q;
endmodule

// File: tb/tb_qspi_target.sv
// tb/tb_qspi_target.sv - scoreboard bench for qspi_target driving directed QSPI transactions
module tb_qspi_target;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        spi_clk_in = 1'b0;
    logic        spi_cs_n_in = 1'b1;
    logic [3:0]  spi_data_in = 4'h0;
    logic [3:0]  spi_data_out, spi_data_oe;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_rd_req, busy, rd_underrun;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        mem_rd_valid = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] exp_we[$];
    logic [3:0]  exp_nib[$];
    bit          rd_phase = 1'b0;
    bit          slow_en = 1'b0;

    logic        svc = 1'b0;
    int          lat_cnt = 0;
    logic [15:0] svc_addr = 16'h0;

    qspi_target dut (
        .clock(clock), .reset(reset), .spi_clk_in(spi_clk_in), .spi_cs_n_in(spi_cs_n_in),
        .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rd_req(mem_rd_req),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .busy(busy), .rd_underrun(rd_underrun)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mem_lookup(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h5A;
            16'h0011: return 8'hC3;
            default:  return 8'h00;
        endcase
    endfunction

    // Memory model: 2-clock latency, 40 clocks for address 0x0011 when slow_en is set
    always @(posedge clock) begin
        if (mem_rd_valid) begin
            mem_rd_valid <= 1'b0;
        end else if (svc) begin
            if (lat_cnt <= 1) begin
                mem_rd_valid <= 1'b1; mem_rd_data <= mem_lookup(svc_addr); svc <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end else if (mem_rd_req) begin
            svc <= 1'b1; svc_addr <= mem_addr;
            lat_cnt <= (slow_en && mem_addr == 16'h0011) ? 40 : 2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mem_we && mem_rd_req) begin
            miscompares++;
            $display("FAIL we_and_req: both high at %0t", $time);
        end
        if (mem_we) begin
            if (exp_we.size() == 0) begin
                miscompares++;
                $display("FAIL we_unexpected: addr %0h data %0h expected none", mem_addr, mem_wdata);
            end else begin
                chk("mem_we", 32'({mem_addr, mem_wdata}), 32'(exp_we.pop_front()));
            end
        end
    end

    always @(posedge spi_clk_in) begin
        if (rd_phase) begin
            if (exp_nib.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: nibble %0h expected none", spi_data_out);
            end else begin
                chk("rd_nibble", 32'(spi_data_out), 32'(exp_nib.pop_front()));
            end
            chk("rd_oe", 32'(spi_data_oe), 32'hF);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic sck_cycle(input logic [3:0] d);
        spi_data_in = d;
        clks(5); spi_clk_in = 1'b1;
        clks(5); spi_clk_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        sck_cycle(b[7:4]);
        sck_cycle(b[3:0]);
    endtask

    task automatic cs_start();
        spi_cs_n_in = 1'b0; clks(5);
    endtask

    task automatic cs_end();
        clks(5); spi_cs_n_in = 1'b1; clks(10);
    endtask

    task automatic spi_read(input logic [23:0] a, input int ndata);
        cs_start();
        send_byte(8'h0B); send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
        repeat (5) sck_cycle(4'h0);
        chk("oe_in_dummy", 32'(spi_data_oe), 32'h0);
        sck_cycle(4'h0);
        rd_phase = 1'b1;
        repeat (ndata) sck_cycle(4'h0);
        rd_phase = 1'b0;
        cs_end();
        chk("oe_after_read", 32'(spi_data_oe), 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"},   32'(spi_data_out), 32'h0);
        chk({tag, "_oe"},    32'(spi_data_oe), 32'h0);
        chk({tag, "_addr"},  32'(mem_addr), 32'h0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
        chk({tag, "_we"},    32'(mem_we), 32'h0);
        chk({tag, "_req"},   32'(mem_rd_req), 32'h0);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_unr"},   32'(rd_underrun), 32'h0);
    endtask

    initial begin
        #1;
        chk_all_zero("reset");
        clks(3); reset = 1'b1; clks(5);

        exp_we.push_back({16'h1234, 8'hA5}); exp_we.push_back({16'h1235, 8'h3C});
        cs_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hA5); send_byte(8'h3C);
        chk("wr_busy", 32'(busy), 32'h1);
        chk("wr_oe", 32'(spi_data_oe), 32'h0);
        cs_end();
        chk("wr_idle", 32'(busy), 32'h0);

        exp_we.push_back({16'hFFFF, 8'h11}); exp_we.push_back({16'h0000, 8'h22});
        cs_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h11); send_byte(8'h22);
        cs_end();
        chk("wrap_addr", 32'(mem_addr), 32'h0001);

        exp_nib.push_back(4'h5); exp_nib.push_back(4'hA);
        exp_nib.push_back(4'hC); exp_nib.push_back(4'h3);
        spi_read(24'h000010, 4);
        chk("rd_no_underrun", 32'(rd_underrun), 32'h0);
        clks(20);

        slow_en = 1'b1;
        exp_nib.push_back(4'h5); exp_nib.push_back(4'hA);
        exp_nib.push_back(4'h0); exp_nib.push_back(4'h0);
        spi_read(24'h000010, 4);
        slow_en = 1'b0;
        chk("underrun_set", 32'(rd_underrun), 32'h1);
        spi_cs_n_in = 1'b0; clks(5);
        chk("underrun_cleared", 32'(rd_underrun), 32'h0);
        chk("cs_only_busy", 32'(busy), 32'h1);
        spi_cs_n_in = 1'b1; clks(60);
        chk("cs_only_idle", 32'(busy), 32'h0);

        cs_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        sck_cycle(4'h7);
        chk("abort_busy", 32'(busy), 32'h1);
        spi_cs_n_in = 1'b1; clks(3);
        chk("abort_idle", 32'(busy), 32'h0);
        chk("abort_oe", 32'(spi_data_oe), 32'h0);
        clks(10);

        cs_start();
        send_byte(8'h9F); send_byte(8'h00); send_byte(8'h00);
        chk("ign_busy", 32'(busy), 32'h1);
        chk("ign_req", 32'(mem_rd_req), 32'h0);
        chk("ign_oe", 32'(spi_data_oe), 32'h0);
        cs_end();

        cs_start();
        send_byte(8'h0B); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        repeat (3) sck_cycle(4'h0);
        chk("pre_reset_addr", 32'(mem_addr), 32'h0010);
        chk("pre_reset_busy", 32'(busy), 32'h1);
        #2 reset = 1'b0;
        #1 chk_all_zero("midrst");
        clks(3); spi_cs_n_in = 1'b1; clks(2); reset = 1'b1; clks(10);

        exp_nib.push_back(4'h5); exp_nib.push_back(4'hA);
        exp_nib.push_back(4'hC); exp_nib.push_back(4'h3);
        spi_read(24'h000010, 4);
        chk("post_reset_underrun", 32'(rd_underrun), 32'h0);

        clks(20);
        chk("we_left", 32'(exp_we.size()), 32'h0);
        chk("nib_left", 32'(exp_nib.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/qspi_target.md
Name: qspi_target

Overview:
- Synthesizable quad-SPI responder: the external-facing counterpart of the QSPI initiator used by the memory unit.
- Lets an external QSPI master (test harness or a second chip) read and write a local byte-addressed memory, e.g. a preload/debug RAM port.
- Oversamples the QSPI pins in the system clock domain and decodes command/address/dummy/data phases.
- Drives a simple single-byte memory-side interface.

Parameters:
ADDRESS_WIDTH, 16, width of mem_addr; low bits of the received 24-bit address
DUMMY_CYCLES, 6, SCK cycles between the last address nibble and the first read-data nibble
CMD_READ, 8'h0B, opcode for quad read
CMD_WRITE, 8'h02, opcode for quad write

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
spi_clk_in  in  1  SCK from master, asynchronous
spi_cs_n_in  in  1  chip select, active-low, asynchronous
spi_data_in  in  4  IO[3:0] from master
spi_data_out  out  4  IO[3:0] driven to master
spi_data_oe  out  4  output enables, all bits equal
mem_addr  out  ADDRESS_WIDTH  byte address to local memory
mem_wdata  out  8  write data
mem_we  out  1  one-clock write strobe
mem_rd_req  out  1  read request, held until mem_rd_valid
mem_rd_data  in  8  read data
mem_rd_valid  in  1  read data valid; completes the request
busy  out  1  high while CS is asserted and a command is being handled
rd_underrun  out  1  sticky flag: read byte not ready in time; cleared by next CS fall

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; synchronizers cleared.
- Input sync: SCK, CS_n and IO each pass through 2 flops.
  - SCK edges are detected on the synchronized signal (rise = sample, fall = shift out).
  - Event latency from pin is 2-3 clocks.
  - Supported f_SCK ≤ f_clock/8, SPI mode 0.
- All phases are quad: one nibble per SCK rise, high nibble first.
- States:
  - IDLE -> CMD on synchronized CS fall; clears rd_underrun.
  - CMD: 2 nibbles. Opcode CMD_READ or CMD_WRITE -> ADDR; any other opcode -> IGNORE.
  - ADDR: 6 nibbles, MSB first, 24 bits. mem_addr loads addr[ADDRESS_WIDTH-1:0] on the last nibble. Next state: DUMMY (read) or WR_DATA (write).
  - DUMMY: entry raises mem_rd_req for mem_addr. Counts DUMMY_CYCLES SCK rises. On the SCK fall following the last dummy rise: oe=4'hF, spi_data_out = byte[7:4], -> RD_DATA.
  - RD_DATA: each SCK fall presents the next nibble. After the low nibble of byte n is presented:
    - mem_addr increments;
    - mem_rd_req is raised for byte n+1;
    - the returned byte is latched in a prefetch register.
    - If the prefetch is not valid when the high nibble of byte n+1 must be driven: drive 4'h0 for that byte and set rd_underrun. The request stays outstanding and its data is discarded.
  - WR_DATA: two rises assemble a byte. On the second rise: mem_wdata = byte, mem_we pulses for 1 clock at the current mem_addr, then mem_addr increments one clock later.
  - IGNORE: no memory activity, oe=0, until CS rise.
- Address increment wraps modulo 2^ADDRESS_WIDTH (0xFFFF -> 0x0000 at default).
- CS rise in any state -> IDLE within 3 clocks of the pin edge, with:
  - oe=0;
  - mem_we not asserted for an incomplete byte (a partial nibble is discarded);
  - a pending mem_rd_req dropped, and a late mem_rd_valid ignored.
- CS fall and rise arriving within the same synchronized sample: treated as no transaction.
- SCK edges while CS is high are ignored.
- mem_rd_req and mem_we are never high simultaneously.
- busy = (state != IDLE).
- spi_data_oe is only nonzero in RD_DATA.

Test Plan:
- Write: CS low, nibbles 0,2 / 00,12,34 / A,5 / 3,C, CS high -> mem_we pulses twice: addr 0x1234 data 0xA5, then addr 0x1235 data 0x3C; no oe activity.
- Read: memory returns 0x5A @0x0010 and 0xC3 @0x0011 with 2-clock latency. Opcode 0x0B, addr 0x000010, 6 dummy clocks, 4 data clocks -> master samples 5,A,C,3; rd_underrun=0; oe=4'hF only during data.
- Wrap: write 2 bytes starting at addr 0x00FFFF (ADDRESS_WIDTH=16) -> writes to 0xFFFF then 0x0000.
- Underrun: mem_rd_valid delayed by 40 clocks on the second byte -> second byte reads as 0x00, rd_underrun=1. Next CS fall clears rd_underrun.
- Abort: CS rises after 1 data nibble of a write -> no mem_we; busy=0 and oe=0 within 3 clocks. Unknown opcode 0x9F -> no memory strobes, oe stays 0.
- Async reset asserted mid-read -> all outputs 0 immediately. After release plus a fresh CS cycle, the read works normally.
